// File: rtl/univ_shift_reg_pkg.sv
// Shared types and the single-step shift/rotate function for univ_shift_reg.
// The step function works on a MAX_W-wide container; callers pass their real width.
package univ_shift_reg_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_SHL    = 3'd2,
    OP_SHR    = 3'd3,
    OP_ROL    = 3'd4,
    OP_ROR    = 3'd5,
    OP_TOGGLE = 3'd6,
    OP_CLEAR  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [MAX_W-1:0] q;
    logic             ej;
  } step_t;

  function automatic logic is_shift_op(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // One shift/rotate step on the low w bits of q; bits above w stay zero.
  function automatic step_t step(input logic [MAX_W-1:0] q, input op_e op,
                                 input logic sin, input int w);
    logic [MAX_W-1:0] msb_m;
    logic [MAX_W-1:0] mask;
    logic             msb;
    logic             lsb;
    step_t            r;
    msb_m = MAX_W'(1) << (w - 1);
    // when w == MAX_W the shifted term wraps to zero and mask becomes all ones
    mask  = (msb_m << 1) - MAX_W'(1);
    msb   = |(q & msb_m);
    lsb   = q[0];
    r.q   = q;
    r.ej  = 1'b0;
    case (op)
      OP_SHL: begin
        r.q  = ((q << 1) | MAX_W'(sin)) & mask;
        r.ej = msb;
      end
      OP_SHR: begin
        r.q  = (q >> 1) | (sin ? msb_m : '0);
        r.ej = lsb;
      end
      OP_ROL: begin
        r.q  = ((q << 1) | MAX_W'(msb)) & mask;
        r.ej = msb;
      end
      OP_ROR: begin
        r.q  = (q >> 1) | (lsb ? msb_m : '0);
        r.ej = lsb;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Request/result bundle for univ_shift_reg; master issues ops, slave is the register.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 4
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic [AMTW-1:0]  amt;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, d, amt, sin,
    input  q, qbar, sout, busy, done
  );

  modport slave (
    input  start, op, d, amt, sin,
    output q, qbar, sout, busy, done
  );

endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: load/clear/toggle/hold in one edge, shift/rotate
// by amt steps at one bit per clock, with start/busy/done sequencing.
//
// state  | meaning
// S_IDLE | waiting for start; request fields sampled here only
// S_RUN  | multi-step shift/rotate in progress, rem_q steps left
// S_DONE | done pulse cycle; start ignored
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMTW  = 4
) (
  input logic            clk,
  input logic            rst,
  univ_shift_reg_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  op_e              op_q, op_d;
  logic [AMTW-1:0]  rem_q, rem_d;

  op_e              req_op;
  step_t            acc_step;
  step_t            run_step;
  logic             step_unused;

  assign req_op   = op_e'(bus.op);
  assign acc_step = step(MAX_W'(q_q), req_op, bus.sin, WIDTH);
  assign run_step = step(MAX_W'(q_q), op_q, bus.sin, WIDTH);
  // container bits above WIDTH are always zero
  assign step_unused = ^{acc_step, run_step};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    op_d    = op_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_DONE;
          if (is_shift_op(req_op)) begin
            if (bus.amt != '0) begin
              q_d    = acc_step.q[WIDTH-1:0];
              sout_d = acc_step.ej;
              if (bus.amt != AMTW'(1)) begin
                op_d    = req_op;
                rem_d   = bus.amt - AMTW'(1);
                state_d = S_RUN;
              end
            end
          end else begin
            case (req_op)
              OP_LOAD:   q_d = bus.d;
              OP_TOGGLE: q_d = q_q ^ bus.d;
              OP_CLEAR:  q_d = '0;
              default:   ;
            endcase
          end
        end
      end
      S_RUN: begin
        q_d    = run_step.q[WIDTH-1:0];
        sout_d = run_step.ej;
        rem_d  = rem_q - AMTW'(1);
        if (rem_q == AMTW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // register the decoded flags so done/busy are clean flop outputs
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  assign bus.q    = q_q;
  assign bus.qbar = ~q_q;
  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus random ops
// checked cycle by cycle against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int W    = 8;
  localparam int AW   = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  univ_shift_reg_if #(.WIDTH(W), .AMTW(AW)) bus ();

  univ_shift_reg #(.WIDTH(W), .AMTW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int m_q          = 0;
  int m_sout       = 0;

  function automatic int pick_sin(input int mode);
    if (mode == 2) return int'($urandom_range(0, 1));
    return mode & 1;
  endfunction

  // Reference: one step applied with plain integer arithmetic.
  task automatic model_step(input int op, input int s);
    int v;
    v = m_q;
    case (op)
      2: begin m_sout = (v >> (W - 1)) & 1; m_q = ((v << 1) | s) & MASK; end
      3: begin m_sout = v & 1;              m_q = (v >> 1) | (s << (W - 1)); end
      4: begin m_sout = (v >> (W - 1)) & 1; m_q = ((v << 1) | (v >> (W - 1))) & MASK; end
      5: begin m_sout = v & 1;              m_q = (v >> 1) | ((v & 1) << (W - 1)); end
      default: ;
    endcase
  endtask

  // Issue one request and check every cycle until the register is idle again.
  // inject drives a LOAD 00 request during RUN and during DONE.
  task automatic exec_op(input string name, input int op, input int dv, input int amt,
                         input int sin_mode, input bit inject);
    int n, steps, s, busy_cnt, done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    n        = (op >= 2 && op <= 5) ? amt : 0;
    steps    = (n < 2) ? 1 : n;
    @(negedge clk);
    s         = pick_sin(sin_mode);
    bus.start = 1'b1;
    bus.op    = 3'(op);
    bus.d     = W'(dv);
    bus.amt   = AW'(amt);
    bus.sin   = 1'(s);
    case (op)
      1:       m_q = dv & MASK;
      6:       m_q = (m_q ^ dv) & MASK;
      7:       m_q = 0;
      2, 3, 4, 5: if (n > 0) model_step(op, s);
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= steps; k++) begin
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      tests_run++;
      if ({bus.q, bus.qbar, bus.sout, bus.busy, bus.done} !==
          {W'(m_q), ~(W'(m_q)), 1'(m_sout), 1'b1, 1'(k == steps)}) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: q=%h qbar=%h sout=%b busy=%b done=%b, required q=%h qbar=%h sout=%b busy=1 done=%b",
                 name, k, bus.q, bus.qbar, bus.sout, bus.busy, bus.done,
                 W'(m_q), ~(W'(m_q)), 1'(m_sout), 1'(k == steps));
      end
      if (k < steps) begin
        s       = pick_sin(sin_mode);
        bus.sin = 1'(s);
        if (inject && k == 2) begin
          bus.start = 1'b1;
          bus.op    = 3'd1;
          bus.d     = '0;
          bus.amt   = AW'(1);
        end
        @(posedge clk);
        model_step(op, s);
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    if (inject) begin
      bus.start = 1'b1;
      bus.op    = 3'd1;
      bus.d     = '0;
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if ({bus.q, bus.sout, bus.busy, bus.done} !== {W'(m_q), 1'(m_sout), 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s idle: q=%h sout=%b busy=%b done=%b, required q=%h sout=%b busy=0 done=0",
               name, bus.q, bus.sout, bus.busy, bus.done, W'(m_q), 1'(m_sout));
    end
    tests_run++;
    if (busy_cnt != steps || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s pulse count: busy cycles=%0d done pulses=%0d, required %0d and 1",
               name, busy_cnt, done_cnt, steps);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op    = '0;
    bus.d     = '0;
    bus.amt   = '0;
    bus.sin   = 1'b0;
    rst       = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.q, bus.qbar, bus.sout, bus.busy, bus.done} !== {8'h00, 8'hFF, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset: q=%h qbar=%h sout=%b busy=%b done=%b, required 00 ff 0 0 0",
               bus.q, bus.qbar, bus.sout, bus.busy, bus.done);
    end
    rst    = 1'b1;
    m_q    = 0;
    m_sout = 0;
  endtask

  task automatic test_load();
    exec_op("load_a5", 1, 'hA5, 0, 0, 1'b0);
    tests_run++;
    if (bus.qbar !== 8'h5A) begin
      tests_failed++;
      $display("FAIL load_qbar: qbar=%h, required 5a", bus.qbar);
    end
  endtask

  task automatic test_shl3();
    exec_op("shl3", 2, 0, 3, 1, 1'b0);
    tests_run++;
    if ({bus.q, bus.sout} !== {8'h2F, 1'b1}) begin
      tests_failed++;
      $display("FAIL shl3_final: q=%h sout=%b, required 2f 1", bus.q, bus.sout);
    end
  endtask

  task automatic test_ror_width();
    exec_op("ror_width", 5, 0, W, 2, 1'b0);
    tests_run++;
    if (bus.q !== 8'h2F) begin
      tests_failed++;
      $display("FAIL ror_width_restore: q=%h, required 2f", bus.q);
    end
  endtask

  task automatic test_toggle_clear();
    exec_op("toggle_ff", 6, 'hFF, 0, 2, 1'b0);
    tests_run++;
    if (bus.q !== 8'hD0) begin
      tests_failed++;
      $display("FAIL toggle_value: q=%h, required d0", bus.q);
    end
    exec_op("clear", 7, 'h5C, 3, 2, 1'b0);
  endtask

  task automatic test_busy_ignore();
    exec_op("load_pre", 1, 'hC3, 0, 0, 1'b0);
    exec_op("shr5_inject", 3, 0, 5, 2, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    exec_op("load_rol", 1, 'h96, 0, 0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.amt   = AW'(6);
    bus.sin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rol_running: busy=%b, required 1", bus.busy);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.q, bus.sout, bus.busy, bus.done} !== {8'h00, 3'b000}) begin
      tests_failed++;
      $display("FAIL async_reset: q=%h sout=%b busy=%b done=%b, required 00 0 0 0",
               bus.q, bus.sout, bus.busy, bus.done);
    end
    m_q    = 0;
    m_sout = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.q, bus.busy, bus.done} !== {8'h00, 2'b00}) begin
        tests_failed++;
        $display("FAIL post_reset_quiet %0d: q=%h busy=%b done=%b, required 00 0 0",
                 i, bus.q, bus.busy, bus.done);
      end
    end
    exec_op("load_3c", 1, 'h3C, 0, 0, 1'b0);
    exec_op("shl_amt0", 2, 'hFF, 0, 1, 1'b0);
    tests_run++;
    if (bus.q !== 8'h3C) begin
      tests_failed++;
      $display("FAIL shl_amt0_value: q=%h, required 3c", bus.q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      exec_op("random", int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
              int'($urandom_range(0, (1 << AW) - 1)), 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl3();
    test_ror_width();
    test_toggle_clear();
    test_busy_ignore();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
